// File: rtl/tempo_sequencer.sv
// Game-phase FSM and tempo scheduler for the DDR core: selects a tempo rate by
// level, turns its rising edges into scroll/spawn strobes, and tracks lives.
module tempo_sequencer #(
    parameter int LIVES_INIT      = 3,
    parameter int STEPS_PER_LEVEL = 16,
    parameter int SPAWN_DIV       = 2,
    parameter int OVER_TICKS      = 384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       miss,
    input  logic       display_tick,
    input  logic       rate_1hz,
    input  logic       rate_2hz,
    input  logic       rate_4hz,
    output logic [1:0] state,
    output logic [1:0] level,
    output logic [1:0] lives,
    output logic       scroll_step,
    output logic       spawn
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_GAME  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);
    localparam logic [7:0]  STEP_MAX   = 8'(STEPS_PER_LEVEL - 1);
    localparam logic [3:0]  SPAWN_MAX  = 4'(SPAWN_DIV - 1);
    localparam logic [15:0] OVER_MAX   = 16'(OVER_TICKS - 1);

    state_e      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [3:0]  spawn_cnt_q, spawn_cnt_d;
    logic [15:0] over_cnt_q, over_cnt_d;
    logic [2:0]  rate_hist_q;
    logic        scroll_q, scroll_d;
    logic        spawn_q, spawn_d;

    logic [2:0]  rate_now;
    logic        rate_sel;
    logic        hist_sel;
    logic        rate_rise;

    assign rate_now = {rate_4hz, rate_2hz, rate_1hz};

    // Levels 2 and 3 share the fastest rate.
    always_comb begin
        rate_sel = rate_now[2];
        hist_sel = rate_hist_q[2];
        case (level_q)
            2'd0: begin
                rate_sel = rate_now[0];
                hist_sel = rate_hist_q[0];
            end
            2'd1: begin
                rate_sel = rate_now[1];
                hist_sel = rate_hist_q[1];
            end
            default: begin
                rate_sel = rate_now[2];
                hist_sel = rate_hist_q[2];
            end
        endcase
        rate_rise = rate_sel & ~hist_sel;
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        lives_d     = lives_q;
        step_cnt_d  = step_cnt_q;
        spawn_cnt_d = spawn_cnt_q;
        over_cnt_d  = over_cnt_q;
        scroll_d    = 1'b0;
        spawn_d     = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (start_btn) begin
                    state_d     = ST_GAME;
                    lives_d     = LIVES_LOAD;
                    level_d     = 2'd0;
                    step_cnt_d  = 8'd0;
                    spawn_cnt_d = 4'd0;
                    over_cnt_d  = 16'd0;
                end
            end

            ST_GAME: begin
                if (rate_rise) begin
                    scroll_d    = 1'b1;
                    spawn_d     = (spawn_cnt_q == 4'd0);
                    spawn_cnt_d = (spawn_cnt_q == SPAWN_MAX) ? 4'd0 : spawn_cnt_q + 4'd1;
                    if (step_cnt_q == STEP_MAX) begin
                        step_cnt_d = 8'd0;
                        if (level_q != 2'd3) begin
                            level_d = level_q + 2'd1;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end
                end

                // A fatal miss wins over a simultaneous pause.
                if (miss && lives_q == 2'd1) begin
                    lives_d    = 2'd0;
                    state_d    = ST_OVER;
                    over_cnt_d = 16'd0;
                end else begin
                    if (miss && lives_q != 2'd0) begin
                        lives_d = lives_q - 2'd1;
                    end
                    if (pause_btn) begin
                        state_d = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (pause_btn) begin
                    state_d = ST_GAME;
                end
            end

            ST_OVER: begin
                if (start_btn) begin
                    state_d = ST_RESET;
                end else if (display_tick) begin
                    if (over_cnt_q == OVER_MAX) begin
                        state_d = ST_RESET;
                    end else begin
                        over_cnt_d = over_cnt_q + 16'd1;
                    end
                end
            end

            default: state_d = ST_RESET;
        endcase
    end

    // Rate history updates in every state so resume or a level change never
    // sees a stale low sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            level_q     <= 2'd0;
            lives_q     <= LIVES_LOAD;
            step_cnt_q  <= 8'd0;
            spawn_cnt_q <= 4'd0;
            over_cnt_q  <= 16'd0;
            rate_hist_q <= 3'd0;
            scroll_q    <= 1'b0;
            spawn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            step_cnt_q  <= step_cnt_d;
            spawn_cnt_q <= spawn_cnt_d;
            over_cnt_q  <= over_cnt_d;
            rate_hist_q <= rate_now;
            scroll_q    <= scroll_d;
            spawn_q     <= spawn_d;
        end
    end

    assign state       = state_q;
    assign level       = level_q;
    assign lives       = lives_q;
    assign scroll_step = scroll_q;
    assign spawn       = spawn_q;

endmodule
